// File: rtl/enc_pkg.sv
// Shared types and helpers for the 8-to-3 scanning priority encoder.
// Line 7 is highest priority and maps to code 0; line 0 maps to code 7.
package enc_pkg;

  localparam int LINES  = 8;
  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    REPORT,
    RELEASE
  } state_t;

  // Later (higher) bits override earlier ones, giving bit7 priority.
  function automatic logic [CODE_W-1:0] prio_encode(
    input logic [LINES-1:0] m
  );
    logic [CODE_W-1:0] c;
    c = '0;
    for (int i = 0; i < LINES; i++) begin
      if (m[i]) c = CODE_W'(LINES - 1 - i);
    end
    return c;
  endfunction

  function automatic logic multi_bits(
    input logic [LINES-1:0] m
  );
    return (m & (m - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/enc_line_sync.sv
// Multi-stage synchronizer for the asynchronous request lines.
// Resets to all-ones so released (idle-high) lines read as inactive.
module enc_line_sync
  import enc_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LINES-1:0] d,
  output logic [LINES-1:0] q
);

  logic [LINES-1:0] ff [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        ff[i] <= '1;
      end
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/enc8_3_scan.sv
// Debounced registered 8-to-3 priority encoder with valid/ready output.
// Optional ENC_MULTI_FLAG_EN adds multi_o (several lines in the press).
module enc8_3_scan
  import enc_pkg::*;
#(
  parameter int DB_CYCLES   = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINES-1:0]  a_n,
  input  logic              ready_i,
  output logic [CODE_W-1:0] code_o,
  output logic              valid_o,
  output logic              err_o
`ifdef ENC_MULTI_FLAG_EN
  ,
  output logic              multi_o
`endif
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [LINES-1:0] sync_out;
  logic [LINES-1:0] act;
  logic [LINES-1:0] mask;
  logic [CW-1:0]    cnt;
  state_t           state;

  enc_line_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (a_n),
    .q   (sync_out)
  );

  assign act = ~sync_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mask    <= '0;
      code_o  <= '0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
`ifdef ENC_MULTI_FLAG_EN
      multi_o <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (act != '0) begin
            mask  <= act;
            cnt   <= '0;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (act == '0) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (act != mask) begin
            mask <= act;
            cnt  <= '0;
          end else if (cnt == CNT_LAST) begin
            code_o  <= prio_encode(mask);
            valid_o <= 1'b1;
`ifdef ENC_MULTI_FLAG_EN
            multi_o <= multi_bits(mask);
`endif
            cnt     <= '0;
            state   <= REPORT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REPORT: begin
          if (valid_o && ready_i) begin
            valid_o <= 1'b0;
            cnt     <= '0;
            state   <= RELEASE;
          end else if (act != '0 && act != mask) begin
            // A different press while the single slot is still full.
            if (cnt == CNT_LAST) err_o <= 1'b1;
            else cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        RELEASE: begin
          if (act != '0) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef ENC_MULTI_FLAG_EN
  logic unused_multi;
  assign unused_multi = multi_bits(mask);
`endif

endmodule

// File: tb/tb_enc8_3_scan.sv
// Directed self-checking bench for enc8_3_scan.
// Runs with DB_CYCLES=4, SYNC_STAGES=2.
module tb_enc8_3_scan;

  logic       clk;
  logic       rst;
  logic [7:0] a_n;
  logic       ready_i;
  logic [2:0] code_o;
  logic       valid_o;
  logic       err_o;
`ifdef ENC_MULTI_FLAG_EN
  logic       multi_o;
`endif

  int checks;
  int failures;

  enc8_3_scan #(
    .DB_CYCLES   (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a_n     (a_n),
    .ready_i (ready_i),
    .code_o  (code_o),
    .valid_o (valid_o),
    .err_o   (err_o)
`ifdef ENC_MULTI_FLAG_EN
    ,
    .multi_o (multi_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (valid_o === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic settle_idle();
    a_n = 8'hFF;
    repeat (12) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_n = 8'h00;
    ready_i = 1'b0;
    step();
    checks++;
    if (valid_o !== 1'b0 || code_o !== 3'b000 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_c1 got v=%b c=%b e=%b exp 0/000/0",
               valid_o, code_o, err_o);
    end
    step();
    checks++;
    if (valid_o !== 1'b0 || code_o !== 3'b000 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_c2 got v=%b c=%b e=%b exp 0/000/0",
               valid_o, code_o, err_o);
    end
`ifdef ENC_MULTI_FLAG_EN
    checks++;
    if (multi_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_multi got=%b exp=0", multi_o);
    end
`endif
    rst = 1'b0;
    step();
    checks++;
    if (valid_o !== 1'b0 || code_o !== 3'b000 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_after got v=%b c=%b e=%b exp 0/000/0",
               valid_o, code_o, err_o);
    end
    settle_idle();
  endtask

  task automatic test_single_press();
    int first;
    int extra;
    first = 0;
    a_n = 8'hDF;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (valid_o === 1'b1 && first == 0) first = i;
    end
    checks++;
    if (first != 7) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=7", first);
    end
    checks++;
    if (code_o !== 3'b010) begin
      failures++;
      $display("FAIL single_code got=%b exp=010", code_o);
    end
`ifdef ENC_MULTI_FLAG_EN
    checks++;
    if (multi_o !== 1'b0) begin
      failures++;
      $display("FAIL single_multi got=%b exp=0", multi_o);
    end
`endif
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0) begin
      failures++;
      $display("FAIL single_accept got=%b exp=0", valid_o);
    end
    checks++;
    if (code_o !== 3'b010) begin
      failures++;
      $display("FAIL single_hold_code got=%b exp=010", code_o);
    end
    extra = 0;
    ready_i = 1'b1;
    repeat (20) begin
      step();
      if (valid_o === 1'b1) extra++;
    end
    ready_i = 1'b0;
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL single_no_repeat got=%0d exp=0", extra);
    end
    settle_idle();
  endtask

  task automatic test_priority();
    int n;
    a_n = 8'h7E;
    wait_valid(20, n);
    checks++;
    if (n < 0) begin
      failures++;
      $display("FAIL prio_timeout got=none exp=valid");
    end
    checks++;
    if (code_o !== 3'b000) begin
      failures++;
      $display("FAIL prio_code got=%b exp=000", code_o);
    end
`ifdef ENC_MULTI_FLAG_EN
    checks++;
    if (multi_o !== 1'b1) begin
      failures++;
      $display("FAIL prio_multi got=%b exp=1", multi_o);
    end
`endif
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    settle_idle();
  endtask

  task automatic test_bounce();
    int seen;
    int n;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      a_n = (k % 2 == 0) ? 8'hFE : 8'hFF;
      repeat (2) begin
        step();
        if (valid_o === 1'b1) seen++;
      end
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL bounce_early got=%0d exp=0", seen);
    end
    a_n = 8'hFE;
    wait_valid(20, n);
    checks++;
    if (n < 0) begin
      failures++;
      $display("FAIL bounce_timeout got=none exp=valid");
    end
    checks++;
    if (code_o !== 3'b111) begin
      failures++;
      $display("FAIL bounce_code got=%b exp=111", code_o);
    end
  endtask

  task automatic test_release_debounce();
    int seen;
    int n;
    seen = 0;
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0) begin
      failures++;
      $display("FAIL rel_accept got=%b exp=0", valid_o);
    end
    a_n = 8'hFF;
    repeat (2) begin
      step();
      if (valid_o === 1'b1) seen++;
    end
    a_n = 8'hFE;
    step();
    if (valid_o === 1'b1) seen++;
    a_n = 8'hFF;
    repeat (6) begin
      step();
      if (valid_o === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rel_glitch got=%0d exp=0", seen);
    end
    a_n = 8'hFB;
    wait_valid(20, n);
    checks++;
    if (n < 0) begin
      failures++;
      $display("FAIL rel_timeout got=none exp=valid");
    end
    checks++;
    if (code_o !== 3'b101) begin
      failures++;
      $display("FAIL rel_code got=%b exp=101", code_o);
    end
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    seen = 0;
    repeat (10) begin
      step();
      if (valid_o === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rel_single got=%0d exp=0", seen);
    end
    settle_idle();
  endtask

  task automatic test_overrun_reset();
    int n;
    a_n = 8'hBF;
    wait_valid(20, n);
    checks++;
    if (n < 0 || code_o !== 3'b001) begin
      failures++;
      $display("FAIL ovr_pending got=%b n=%0d exp=001", code_o, n);
    end
    a_n = 8'hF7;
    repeat (4) step();
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL ovr_err_early got=%b exp=0", err_o);
    end
    repeat (4) step();
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL ovr_err got=%b exp=1", err_o);
    end
    checks++;
    if (valid_o !== 1'b1 || code_o !== 3'b001) begin
      failures++;
      $display("FAIL ovr_keep got v=%b c=%b exp 1/001",
               valid_o, code_o);
    end
    rst = 1'b1;
    step();
    checks++;
    if (valid_o !== 1'b0 || code_o !== 3'b000 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL ovr_rst got v=%b c=%b e=%b exp 0/000/0",
               valid_o, code_o, err_o);
    end
    rst = 1'b0;
    a_n = 8'hFF;
    step();
    checks++;
    if (valid_o !== 1'b0 || code_o !== 3'b000 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL ovr_post got v=%b c=%b e=%b exp 0/000/0",
               valid_o, code_o, err_o);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    a_n = 8'hFF;
    ready_i = 1'b0;
    #1;
    test_reset();
    test_single_press();
    test_priority();
    test_bounce();
    test_release_debounce();
    test_overrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
